// File: rtl/fifo_burst_reader_if.sv
// rtl/fifo_burst_reader_if.sv - output stream bundle of the FIFO burst reader
interface fifo_burst_reader_if #(
    parameter int c_DATA_WIDTH = 32
);
    logic [c_DATA_WIDTH-1:0] m_data;
    logic                    m_valid;
    logic                    m_last;
    logic                    m_ready;

    modport master (
        output m_data,
        output m_valid,
        output m_last,
        input  m_ready
    );

    modport slave (
        input  m_data,
        input  m_valid,
        input  m_last,
        output m_ready
    );
endinterface

// File: rtl/fifo_burst_reader.sv
// rtl/fifo_burst_reader.sv - burst-oriented read-side consumer of an async FIFO with credit-based output buffer
module fifo_burst_reader #(
    parameter int c_DATA_WIDTH     = 32,
    parameter int c_RD_DEPTH_WIDTH = 9,
    parameter int c_RAM_RD_LATENCY = 1,
    parameter int c_BURST_LEN      = 8,
    parameter int c_BUF_DEPTH      = 4
) (
    input  logic                        rclk,
    input  logic                        rrst_n,
    input  logic                        flush,
    input  logic                        rempty,
    input  logic [c_RD_DEPTH_WIDTH:0]   rd_water_level,
    output logic                        r_en,
    input  logic [c_DATA_WIDTH-1:0]     rd_data,
    fifo_burst_reader_if.master         m,
    output logic                        burst_active,
    output logic                        burst_done
);

    localparam int LW = c_RD_DEPTH_WIDTH + 1;
    localparam int AW = (c_BUF_DEPTH > 1) ? $clog2(c_BUF_DEPTH) : 1;
    localparam int CW = $clog2(c_BUF_DEPTH + c_RAM_RD_LATENCY + 1);

    localparam logic [LW-1:0] BURST_LEN_W = LW'(c_BURST_LEN);
    localparam logic [CW-1:0] BUF_DEPTH_W = CW'(c_BUF_DEPTH);
    localparam logic [AW-1:0] LAST_IDX    = AW'(c_BUF_DEPTH - 1);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_BURST = 1'b1
    } state_t;

    state_t                     state;
    logic [LW-1:0]              len;
    logic [LW-1:0]              cnt;

    logic [c_RAM_RD_LATENCY-1:0] tag_valid;
    logic [c_RAM_RD_LATENCY-1:0] tag_last;

    logic [c_DATA_WIDTH-1:0]    buf_data [c_BUF_DEPTH];
    logic [c_BUF_DEPTH-1:0]     buf_last;
    logic [AW-1:0]              wr_ptr;
    logic [AW-1:0]              rd_ptr;
    logic [CW-1:0]              occ;

    logic [CW-1:0]              inflight;
    logic                       credit_ok;
    logic                       is_last;
    logic                       accept;
    logic                       push;
    logic                       pop;

    function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
        return (p == LAST_IDX) ? '0 : p + AW'(1);
    endfunction

    // Words already requested from the RAM still need a slot when they land.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < c_RAM_RD_LATENCY; i++) begin
            inflight = inflight + CW'(tag_valid[i]);
        end
    end

    assign credit_ok    = (occ + inflight) < BUF_DEPTH_W;
    assign is_last      = (cnt == len - LW'(1));
    assign r_en         = (state == S_BURST) && !rempty && credit_ok;
    assign accept       = r_en;
    assign burst_done   = accept && is_last;
    assign burst_active = (state == S_BURST);

    assign push = tag_valid[c_RAM_RD_LATENCY-1];
    assign pop  = m.m_valid && m.m_ready;

    assign m.m_valid = (occ != '0);
    assign m.m_data  = m.m_valid ? buf_data[rd_ptr] : '0;
    assign m.m_last  = m.m_valid & buf_last[rd_ptr];

    // IDLE always lasts at least one cycle, so the level seen here already
    // accounts for every read of the previous burst.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            state <= S_IDLE;
            len   <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    cnt <= '0;
                    if (rd_water_level >= BURST_LEN_W) begin
                        len   <= BURST_LEN_W;
                        state <= S_BURST;
                    end else if (flush && (rd_water_level != '0)) begin
                        len   <= rd_water_level;
                        state <= S_BURST;
                    end
                end
                S_BURST: begin
                    if (accept) begin
                        cnt <= cnt + LW'(1);
                        if (is_last) begin
                            state <= S_IDLE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            tag_valid <= '0;
            tag_last  <= '0;
        end else begin
            tag_valid[0] <= accept;
            tag_last[0]  <= burst_done;
            for (int i = 1; i < c_RAM_RD_LATENCY; i++) begin
                tag_valid[i] <= tag_valid[i-1];
                tag_last[i]  <= tag_last[i-1];
            end
        end
    end

    // When full, a simultaneous push and pop reuse the slot being vacated.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            for (int i = 0; i < c_BUF_DEPTH; i++) begin
                buf_data[i] <= '0;
            end
            buf_last <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            occ      <= '0;
        end else begin
            if (push) begin
                buf_data[wr_ptr] <= rd_data;
                buf_last[wr_ptr] <= tag_last[c_RAM_RD_LATENCY-1];
                wr_ptr           <= ptr_next(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            case ({push, pop})
                2'b10:   occ <= occ + CW'(1);
                2'b01:   occ <= occ - CW'(1);
                default: occ <= occ;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// tb/tb_fifo_burst_reader.sv - randomized scoreboard bench for fifo_burst_reader
module tb_fifo_burst_reader;
    localparam int DW  = 32;
    localparam int RDW = 9;
    localparam int LAT = 1;
    localparam int BL  = 8;
    localparam int BD  = 4;

    logic           rclk = 1'b0;
    logic           rrst_n;
    logic           flush;
    logic           rempty;
    logic [RDW:0]   rd_water_level;
    logic           r_en;
    logic [DW-1:0]  rd_data;
    logic           burst_active;
    logic           burst_done;

    fifo_burst_reader_if #(.c_DATA_WIDTH(DW)) s_if ();

    fifo_burst_reader #(
        .c_DATA_WIDTH(DW), .c_RD_DEPTH_WIDTH(RDW), .c_RAM_RD_LATENCY(LAT),
        .c_BURST_LEN(BL), .c_BUF_DEPTH(BD)
    ) dut (
        .rclk(rclk), .rrst_n(rrst_n), .flush(flush), .rempty(rempty),
        .rd_water_level(rd_water_level), .r_en(r_en), .rd_data(rd_data),
        .m(s_if), .burst_active(burst_active), .burst_done(burst_done)
    );

    always #5 rclk = ~rclk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int acc_total = 0;
    int last_seen = 0;
    int first_acc_cyc = -1;
    int last_acc_cyc = -1;
    int first_valid_cyc = -1;
    int last_hs_cyc = -1;

    logic [DW-1:0] fifo_q[$];
    logic [DW:0]   exp_q[$];
    bit            force_empty = 0;

    bit            m_busy = 0;
    int            m_cnt = 0;
    int            m_len = 0;
    bit            pv [LAT];
    logic [DW-1:0] pd [LAT];

    bit            hold_pending = 0;
    logic [DW-1:0] h_data;
    logic          h_last;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic update_ctrl();
        rempty         = force_empty || (fifo_q.size() == 0);
        rd_water_level = (RDW+1)'(fifo_q.size());
    endtask

    task automatic push_words(input int n);
        for (int i = 0; i < n; i++) fifo_q.push_back($urandom);
        update_ctrl();
    endtask

    // Controller + RAM model and the burst-rule reference model.
    always @(posedge rclk) begin
        bit            acc;
        bit            was_busy;
        bit            exp_last;
        bit            new_v;
        logic [DW-1:0] w;
        cyc++;
        new_v = 0;
        w = '0;
        acc = (r_en === 1'b1) && (rempty === 1'b0);
        was_busy = m_busy;
        if (!rrst_n) begin
            m_busy = 0;
            m_cnt = 0;
            m_len = 0;
            exp_q.delete();
            for (int i = 0; i < LAT; i++) pv[i] = 0;
        end else begin
            if (!was_busy) chk("r_en_outside_burst", r_en, 0);
            if (r_en === 1'b1) chk("r_en_while_empty", rempty, 0);
            if (dut.push) chk("push_into_full_buffer", (int'(dut.occ) == BD) && !dut.pop, 0);
            exp_last = was_busy && acc && (m_cnt == m_len - 1);
            if (acc || burst_done) chk("burst_done", burst_done, exp_last);
            if (acc) begin
                w = (fifo_q.size() != 0) ? fifo_q.pop_front() : '0;
                new_v = 1;
                acc_total++;
                if (first_acc_cyc < 0) first_acc_cyc = cyc;
                last_acc_cyc = cyc;
                if (was_busy) begin
                    exp_q.push_back({exp_last, w});
                    m_cnt++;
                    if (exp_last) m_busy = 0;
                end
            end
            if (!was_busy) begin
                if (int'(rd_water_level) >= BL) begin
                    m_len = BL; m_cnt = 0; m_busy = 1;
                end else if (flush && rd_water_level != 0) begin
                    m_len = int'(rd_water_level); m_cnt = 0; m_busy = 1;
                end
            end
        end
        #1;
        for (int i = LAT - 1; i > 0; i--) begin
            pv[i] = pv[i-1];
            pd[i] = pd[i-1];
        end
        pv[0] = new_v;
        pd[0] = w;
        rd_data = pv[LAT-1] ? pd[LAT-1] : $urandom;
        update_ctrl();
    end

    // Stream monitor: scoreboard pop plus stability while stalled.
    always @(negedge rclk) begin
        logic [DW:0] e;
        if (!rrst_n) begin
            hold_pending = 0;
        end else begin
            if (hold_pending) begin
                chk("hold_valid", s_if.m_valid, 1);
                chk("hold_data", s_if.m_data, h_data);
                chk("hold_last", s_if.m_last, h_last);
            end
            if (s_if.m_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (s_if.m_valid && s_if.m_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_word", s_if.m_data, 0);
                    fails += (s_if.m_data == 0) ? 1 : 0;
                end else begin
                    e = exp_q.pop_front();
                    chk("m_data", s_if.m_data, e[DW-1:0]);
                    chk("m_last", s_if.m_last, e[DW]);
                end
                if (s_if.m_last) begin
                    last_seen++;
                    last_hs_cyc = cyc;
                end
            end
            hold_pending = s_if.m_valid && !s_if.m_ready;
            h_data = s_if.m_data;
            h_last = s_if.m_last;
        end
    end

    task automatic wait_acc(input int target, input int maxc);
        int n = 0;
        while (acc_total < target && n < maxc) begin
            @(posedge rclk); #1; n++;
        end
        chk("accept_count_reached", acc_total >= target, 1);
    endtask

    task automatic wait_idle(input int maxc);
        int n = 0;
        while (!(!m_busy && exp_q.size() == 0 && s_if.m_valid == 1'b0) && n < maxc) begin
            @(posedge rclk); #1; n++;
        end
        chk("idle_reached", n < maxc, 1);
    endtask

    initial begin
        int base;
        int lbase;
        int vseen;
        rrst_n = 0;
        flush = 0;
        s_if.m_ready = 1;
        rd_data = '0;
        push_words(20);

        repeat (3) @(posedge rclk);
        #1;
        chk("rst_r_en", r_en, 0);
        chk("rst_m_valid", s_if.m_valid, 0);
        chk("rst_m_last", s_if.m_last, 0);
        chk("rst_m_data", s_if.m_data, 0);
        chk("rst_burst_active", burst_active, 0);
        chk("rst_burst_done", burst_done, 0);
        @(negedge rclk);
        rrst_n = 1;
        @(posedge rclk); #1;
        chk("first_r_en_after_reset", r_en, 1);
        chk("burst_active_after_reset", burst_active, 1);
        wait_acc(16, 200);
        wait_idle(200);

        // Level 7: below threshold, no flush.
        push_words(3);
        base = acc_total;
        repeat (100) @(posedge rclk);
        #1;
        chk("no_read_below_burst", acc_total - base, 0);
        first_acc_cyc = -1;
        first_valid_cyc = -1;
        lbase = last_seen;
        push_words(1);
        wait_acc(base + 8, 100);
        wait_idle(100);
        chk("burst_len_8", acc_total - base, 8);
        chk("reads_consecutive", last_acc_cyc - first_acc_cyc, 7);
        chk("first_word_latency", first_valid_cyc - (first_acc_cyc - 1), LAT + 1);
        chk("zero_bubble_stream", last_hs_cyc - first_valid_cyc, 7);
        chk("single_last", last_seen - lbase, 1);

        // Backpressure fills the buffer, then one pop frees one credit.
        s_if.m_ready = 0;
        base = acc_total;
        push_words(8);
        repeat (30) @(posedge rclk);
        #1;
        chk("credit_stall_reads", acc_total - base, BD);
        chk("stall_m_valid", s_if.m_valid, 1);
        s_if.m_ready = 1;
        @(posedge rclk); #1;
        s_if.m_ready = 0;
        repeat (10) @(posedge rclk);
        #1;
        chk("one_pop_one_read", acc_total - base, BD + 1);
        s_if.m_ready = 1;
        wait_acc(base + 8, 100);
        wait_idle(100);

        // Flush-triggered short burst.
        base = acc_total;
        lbase = last_seen;
        push_words(3);
        flush = 1;
        @(posedge rclk); #1;
        flush = 0;
        wait_acc(base + 3, 50);
        wait_idle(100);
        repeat (5) @(posedge rclk);
        #1;
        chk("short_burst_len", acc_total - base, 3);
        chk("short_burst_last", last_seen - lbase, 1);
        chk("short_burst_idle", burst_active, 0);

        // rempty stall mid-burst.
        base = acc_total;
        lbase = last_seen;
        push_words(8);
        wait_acc(base + 3, 50);
        force_empty = 1;
        update_ctrl();
        for (int i = 0; i < 5; i++) begin
            @(posedge rclk); #1;
            chk("r_en_low_while_empty", r_en, 0);
        end
        force_empty = 0;
        update_ctrl();
        wait_acc(base + 8, 100);
        wait_idle(100);
        chk("stalled_burst_len", acc_total - base, 8);
        chk("stalled_burst_last", last_seen - lbase, 1);

        // Reset in the middle of a burst.
        s_if.m_ready = 0;
        base = acc_total;
        push_words(8);
        wait_acc(base + 4, 50);
        rrst_n = 0;
        #1;
        chk("midrst_m_valid", s_if.m_valid, 0);
        chk("midrst_r_en", r_en, 0);
        chk("midrst_burst_active", burst_active, 0);
        fifo_q.delete();
        exp_q.delete();
        update_ctrl();
        repeat (2) @(posedge rclk);
        @(negedge rclk);
        rrst_n = 1;
        s_if.m_ready = 1;
        vseen = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge rclk); #1;
            if (s_if.m_valid) vseen++;
        end
        chk("no_output_after_reset", vseen, 0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            @(posedge rclk); #1;
            if ($urandom_range(0, 3) == 0 && fifo_q.size() < 400) push_words($urandom_range(1, 4));
            s_if.m_ready = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 15) == 0);
            force_empty = ($urandom_range(0, 19) == 0);
            update_ctrl();
        end
        force_empty = 0;
        flush = 1;
        s_if.m_ready = 1;
        update_ctrl();
        begin
            int n = 0;
            while (!(fifo_q.size() == 0 && !m_busy && exp_q.size() == 0 && !s_if.m_valid) && n < 5000) begin
                @(posedge rclk); #1; n++;
            end
            chk("random_drain_done", n < 5000, 1);
        end
        chk("scoreboard_empty", exp_q.size(), 0);
        flush = 0;
        repeat (5) @(posedge rclk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
